regfile_wb_arbiter: RTL and testbench

// Shares the register file's single write-back port between the pipeline WB stage
// (primary) and a multi-cycle auxiliary unit (load/multiply, secondary). Aux results
// are queued in a small FIFO and drained into idle write-port cycles. A starvation

---
 rtl/regfile_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the RF write port between the WB stage
// (primary) and a queued aux unit (secondary), with a starvation stall.
// Ports: clk, rst (async, active-high)
//   pipe_wb_en/dest/data in, pipe_stall out (registered 1-cycle freeze)
//   aux_valid/dest/data in, aux_ready out (FIFO not full)
//   rf_we/dest/data out (write port), pending out (FIFO non-empty)
// Option: RF_ARB_BYPASS_EN lets aux write straight through when idle.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_en,
  input  logic [ADDR_W-1:0] pipe_wb_dest,
  input  logic [DATA_W-1:0] pipe_wb_data,
  output logic              pipe_stall,
  input  logic              aux_valid,
  input  logic [ADDR_W-1:0] aux_dest,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t          mem [FIFO_DEPTH];
  ent_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nx;
  logic          stall_nx;
  logic          empty;
  logic          full;
  logic          pipe_gnt;
  logic          fifo_gnt;
  logic          byp_gnt;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign head     = mem[rd_ptr];
  assign pending  = !empty;

  assign pipe_gnt = !rst && !pipe_stall && pipe_wb_en;
  assign fifo_gnt = !rst && !pipe_gnt && !empty;
`ifdef RF_ARB_BYPASS_EN
  assign byp_gnt  = !rst && !pipe_gnt && empty
                    && aux_valid;
`else
  assign byp_gnt  = 1'b0;
`endif

  // No pop pass-through: a full FIFO refuses
  // aux even in the cycle its head drains.
  assign aux_ready = !rst && (!full || byp_gnt);
  assign push      = aux_valid && aux_ready
                     && !byp_gnt;
  assign pop       = fifo_gnt;

  always_comb begin
    rf_we   = 1'b0;
    rf_dest = '0;
    rf_data = '0;
    unique case (1'b1)
      pipe_gnt: begin
        rf_we   = 1'b1;
        rf_dest = pipe_wb_dest;
        rf_data = pipe_wb_data;
      end
      fifo_gnt: begin
        rf_we   = 1'b1;
        rf_dest = head.dest;
        rf_data = head.data;
      end
`ifdef RF_ARB_BYPASS_EN
      byp_gnt: begin
        rf_we   = 1'b1;
        rf_dest = aux_dest;
        rf_data = aux_data;
      end
`endif
      default: ;
    endcase
  end

  // Counts cycles the head waited behind the pipe;
  // at the limit, one stall cycle forces a drain.
  always_comb begin
    starve_nx = starve;
    stall_nx  = 1'b0;
    if (empty || pop) begin
      starve_nx = '0;
    end else if (starve == SW'(STARVE_MAX - 1)
                 && pipe_wb_en && !pipe_stall) begin
      starve_nx = '0;
      stall_nx  = 1'b1;
    end else begin
      starve_nx = starve + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      pipe_stall <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count + CW'(push) - CW'(pop);
      starve     <= starve_nx;
      pipe_stall <= stall_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dest: aux_dest, data: aux_data};
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbiter.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 2;
  localparam int SM = 4;
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wb_en;
  logic [AW-1:0] pipe_wb_dest;
  logic [DW-1:0] pipe_wb_data;
  logic          pipe_stall;
  logic          aux_valid;
  logic [AW-1:0] aux_dest;
  logic [DW-1:0] aux_data;
  logic          aux_ready;
  logic          rf_we;
  logic [AW-1:0] rf_dest;
  logic [DW-1:0] rf_data;
  logic          pending;

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW),
    .FIFO_DEPTH(D), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en),
    .pipe_wb_dest(pipe_wb_dest),
    .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .aux_valid(aux_valid),
    .aux_dest(aux_dest),
    .aux_data(aux_data),
    .aux_ready(aux_ready),
    .rf_we(rf_we),
    .rf_dest(rf_dest),
    .rf_data(rf_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] drained[$];
  int            wait_cnt;
  bit            mstall;
  bit            acc;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(string tag,
                     logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wait_cnt = 0;
    mstall   = 1'b0;
    acc      = 1'b0;
  endtask

  // One clock: predict the port from the queue
  // and priority rules, compare, then advance.
  task automatic cyc();
    bit            pg, byp, pp, ps, rdy;
    logic          we;
    logic [AW-1:0] d;
    logic [DW-1:0] v;
    int            n;
    @(negedge clk);
    n   = q.size();
    rdy = (n < D);
    pg  = !mstall && pipe_wb_en;
    byp = BYP && !pg && n == 0 && aux_valid;
    we  = 1'b0;
    d   = '0;
    v   = '0;
    if (pg) begin
      we = 1'b1; d = pipe_wb_dest; v = pipe_wb_data;
    end else if (n > 0) begin
      we = 1'b1; d = q[0].d; v = q[0].v;
    end else if (byp) begin
      we = 1'b1; d = aux_dest; v = aux_data;
    end
    chk("rf_we", rf_we, we);
    chk("rf_dest", rf_dest, d);
    chk("rf_data", rf_data, v);
    chk("pending", pending, n > 0);
    chk("aux_ready", aux_ready, rdy);
    chk("pipe_stall", pipe_stall, mstall);
    if (pipe_stall && rf_we)
      drained.push_back(rf_dest);
    pp  = !pg && n > 0;
    ps  = aux_valid && rdy && !byp;
    acc = aux_valid && rdy;
    if (n == 0 || pp) begin
      wait_cnt = 0;
      mstall   = 1'b0;
    end else if (wait_cnt == SM - 1 && pipe_wb_en
                 && !mstall) begin
      wait_cnt = 0;
      mstall   = 1'b1;
    end else begin
      wait_cnt++;
      mstall = 1'b0;
    end
    if (pp) void'(q.pop_front());
    if (ps) q.push_back('{aux_dest, aux_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle();
    pipe_wb_en   = 1'b0;
    pipe_wb_dest = '0;
    pipe_wb_data = '0;
    aux_valid    = 1'b0;
    aux_dest     = '0;
    aux_data     = '0;
  endtask

  int al[3] = '{2, 4, 6};
  int idx;

  initial begin
    rst = 1'b1;
    idle();
    pipe_wb_en = 1'b1;
    aux_valid  = 1'b1;
    #2;
    chk("rst_we", rf_we, 0);
    chk("rst_ready", aux_ready, 0);
    chk("rst_stall", pipe_stall, 0);
    idle();
    do_reset();

    // reset mid-drain with entries queued
    pipe_wb_en = 1'b1;
    pipe_wb_dest = 4'd9;
    pipe_wb_data = 32'h1;
    aux_valid = 1'b1;
    aux_dest = 4'd7;
    aux_data = 32'h77;
    cyc();
    aux_dest = 4'd8;
    aux_data = 32'h88;
    cyc();
    aux_valid = 1'b0;
    pipe_wb_en = 1'b0;
    cyc();
    #1 rst = 1'b1;
    #1;
    chk("t1_in_pend", pending, 0);
    chk("t1_in_we", rf_we, 0);
    chk("t1_in_ready", aux_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    #1;
    chk("t1_pend", pending, 0);
    chk("t1_we", rf_we, 0);
    chk("t1_ready", aux_ready, 1);
    cyc();

    // single aux result with pipe idle
    aux_valid = 1'b1;
    aux_dest = 4'd3;
    aux_data = 32'h11;
    #1;
    chk("t2_same_we", rf_we, BYP);
    cyc();
    aux_valid = 1'b0;
    #1;
    chk("t2_next_we", rf_we, !BYP);
    chk("t2_next_dest", rf_dest, BYP ? 0 : 3);
    chk("t2_next_data", rf_data, BYP ? 0 : 32'h11);
    cyc();

    // starvation stall
    do_reset();
    pipe_wb_en = 1'b1;
    pipe_wb_dest = 4'd1;
    pipe_wb_data = 32'hAA;
    aux_valid = 1'b1;
    aux_dest = 4'd5;
    aux_data = 32'h55;
    cyc();
    aux_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_pipe_dest", rf_dest, 1);
      chk("t3_no_stall", pipe_stall, 0);
      cyc();
    end
    #1;
    chk("t3_stall", pipe_stall, 1);
    chk("t3_dest", rf_dest, 5);
    chk("t3_data", rf_data, 32'h55);
    cyc();
    #1;
    chk("t3_unstall", pipe_stall, 0);
    chk("t3_resume", rf_dest, 1);
    cyc();

    // fill, backpressure, in-order drain
    do_reset();
    drained.delete();
    pipe_wb_en = 1'b1;
    idx = 0;
    aux_valid = 1'b1;
    aux_dest = 4'(al[0]);
    aux_data = 32'h100;
    for (int c = 0; c < 20; c++) begin
      if (c == 2 || c == 5) begin
        #1;
        chk("t4_full", aux_ready, 0);
        chk("t4_pend", pending, 1);
      end
      cyc();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          aux_dest = 4'(al[idx]);
          aux_data = 32'h100 + 32'(idx);
        end else begin
          aux_valid = 1'b0;
        end
      end
    end
    chk("t4_count", drained.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t4_ord%0d", k),
          k < drained.size() ? drained[k] : 4'hF,
          al[k]);
    pipe_wb_en = 1'b0;
    cyc();

    // random traffic
    do_reset();
    idle();
    for (int i = 0; i < 2000; i++) begin
      if (!mstall) begin
        pipe_wb_en   = ($urandom_range(0, 3) != 0);
        pipe_wb_dest = 4'($urandom);
        pipe_wb_data = $urandom;
      end
      if (!aux_valid || acc) begin
        aux_valid = ($urandom_range(0, 2) != 0);
        aux_dest  = 4'($urandom);
        aux_data  = $urandom;
      end
      cyc();
    end
    idle();
    repeat (6) cyc();
    chk("end_empty", pending, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
